// File: rtl/sdspi_arb_pkg.sv
// Shared types for the sdspihost arbiter: FSM states, owner encoding and defaults.
package sdspi_arb_pkg;

  typedef enum logic [2:0] {
    INIT,
    WAIT_RDY,
    IDLE,
    GRANTED,
    DRAIN
  } state_t;

  typedef logic owner_t;

  localparam int RST_CYCLES_DEF = 16;

  function automatic logic [1:0] owner_onehot(input owner_t o);
    return o ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdspi_arb_watchdog.sv
// Busy watchdog: counts enabled cycles and saturates; saturation is the expiry condition.
module sdspi_arb_watchdog #(
  parameter int TIMEOUT_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = &cnt;

endmodule

// File: rtl/sdspi_arbiter.sv
// Shares one sdspihost between two requesters: bring-up, round-robin ownership,
// command/address/data muxing and watchdog recovery of hung transactions.
module sdspi_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int TIMEOUT_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  output logic [1:0]  gnt_o,
  input  logic [1:0]  r_block_i,
  input  logic [1:0]  r_multi_block_i,
  input  logic [1:0]  r_byte_i,
  input  logic [1:0]  w_block_i,
  input  logic [1:0]  w_byte_i,
  input  logic [63:0] block_addr_i,
  input  logic [15:0] data_in_i,
  output logic [7:0]  data_out_o,
  output logic [1:0]  busy_o,
  output logic [1:0]  err_o,
  output logic        timeout_o,
  output logic        host_rst,
  output logic        host_r_block,
  output logic        host_r_multi_block,
  output logic        host_r_byte,
  output logic        host_w_block,
  output logic        host_w_byte,
  output logic [31:0] host_block_addr,
  output logic [7:0]  host_data_in,
  input  logic        host_busy,
  input  logic        host_err,
  input  logic [7:0]  host_data_out
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

  state_t          state;
  owner_t          owner;
  owner_t          rr;
  owner_t          win;
  logic [RC_W-1:0] rst_cnt;
  logic            chg;
  logic            active;
  logic            granted;
  logic            expired;

  // Tie goes to the rr pointer, which always names the requester not last served.
  assign win     = (req_i == 2'b11) ? rr : req_i[1];
  assign active  = (state == WAIT_RDY) || (state == GRANTED) || (state == DRAIN);
  assign granted = (state == GRANTED);

  sdspi_arb_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (active && host_busy),
    .clr     (chg || !host_busy || !active),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT;
      gnt_o     <= 2'b00;
      host_rst  <= 1'b1;
      timeout_o <= 1'b0;
      rr        <= 1'b0;
      owner     <= 1'b0;
      rst_cnt   <= '0;
      chg       <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      chg       <= 1'b0;
      case (state)
        INIT: begin
          if (rst_cnt == RST_LAST) begin
            state    <= WAIT_RDY;
            host_rst <= 1'b0;
            chg      <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (|req_i) begin
            owner <= win;
            gnt_o <= owner_onehot(win);
            rr    <= ~win;
            state <= GRANTED;
            chg   <= 1'b1;
          end
        end
        WAIT_RDY, GRANTED, DRAIN: begin
          // A hung host is recovered by a fresh reset sequence from any waiting state.
          if (expired) begin
            state     <= INIT;
            host_rst  <= 1'b1;
            rst_cnt   <= '0;
            gnt_o     <= 2'b00;
            timeout_o <= 1'b1;
            chg       <= 1'b1;
          end else if (state == GRANTED) begin
            if (!req_i[owner]) begin
              gnt_o <= 2'b00;
              state <= DRAIN;
              chg   <= 1'b1;
            end
          end else if (!host_busy) begin
            state <= IDLE;
            chg   <= 1'b1;
          end
        end
        default: begin
          state    <= INIT;
          host_rst <= 1'b1;
          rst_cnt  <= '0;
          gnt_o    <= 2'b00;
          chg      <= 1'b1;
        end
      endcase
    end
  end

  assign host_r_block       = granted & r_block_i[owner];
  assign host_r_multi_block = granted & r_multi_block_i[owner];
  assign host_r_byte        = granted & r_byte_i[owner];
  assign host_w_block       = granted & w_block_i[owner];
  assign host_w_byte        = granted & w_byte_i[owner];
  assign host_block_addr    = !granted ? 32'd0 : (owner ? block_addr_i[63:32] : block_addr_i[31:0]);
  assign host_data_in       = !granted ? 8'd0 : (owner ? data_in_i[15:8] : data_in_i[7:0]);
  assign data_out_o         = host_data_out;

  always_comb begin
    busy_o = 2'b11;
    err_o  = 2'b00;
    if (granted) begin
      busy_o[owner] = host_busy;
      err_o[owner]  = host_err;
    end
  end

endmodule

// File: tb/tb_sdspi_arbiter.sv
// Scoreboard bench for sdspi_arbiter: directed vectors, expected grants/timeouts queued.
module tb_sdspi_arbiter;

  localparam int RC = 16;
  localparam int TW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i, gnt_o;
  logic [1:0]  r_block_i, r_multi_block_i, r_byte_i, w_block_i, w_byte_i;
  logic [63:0] block_addr_i;
  logic [15:0] data_in_i;
  logic [7:0]  data_out_o;
  logic [1:0]  busy_o, err_o;
  logic        timeout_o, host_rst;
  logic        host_r_block, host_r_multi_block, host_r_byte, host_w_block, host_w_byte;
  logic [31:0] host_block_addr;
  logic [7:0]  host_data_in;
  logic        host_busy, host_err;
  logic [7:0]  host_data_out;

  always #5 clk = ~clk;

  sdspi_arbiter #(.RST_CYCLES(RC), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o),
    .r_block_i(r_block_i), .r_multi_block_i(r_multi_block_i), .r_byte_i(r_byte_i),
    .w_block_i(w_block_i), .w_byte_i(w_byte_i), .block_addr_i(block_addr_i),
    .data_in_i(data_in_i), .data_out_o(data_out_o), .busy_o(busy_o), .err_o(err_o),
    .timeout_o(timeout_o), .host_rst(host_rst), .host_r_block(host_r_block),
    .host_r_multi_block(host_r_multi_block), .host_r_byte(host_r_byte),
    .host_w_block(host_w_block), .host_w_byte(host_w_byte),
    .host_block_addr(host_block_addr), .host_data_in(host_data_in),
    .host_busy(host_busy), .host_err(host_err), .host_data_out(host_data_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [1:0] gnt;
  } gexp_t;

  gexp_t gnt_q[$];
  string to_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push_gnt(input string name, input logic [1:0] g);
    gexp_t e;
    e.name = name;
    e.gnt  = g;
    gnt_q.push_back(e);
  endtask

  task automatic wait_gnt(input logic [1:0] g, input string name);
    for (int i = 0; i < 20 && gnt_o !== g; i++) @(negedge clk);
    check({name, "_wait"}, 32'(gnt_o), 32'(g));
  endtask

  // Monitor: every new non-zero grant and every timeout pulse consumes one expectation.
  logic [1:0] gnt_prev = 2'b00;
  always @(negedge clk) begin
    gexp_t e;
    string tname;
    if (rst === 1'b1 && gnt_o !== gnt_prev && gnt_o !== 2'b00) begin
      if (gnt_q.size() == 0) check("unexpected_grant", 32'(gnt_o), 32'd0);
      else begin
        e = gnt_q.pop_front();
        check(e.name, 32'(gnt_o), 32'(e.gnt));
      end
    end
    if (rst === 1'b1 && timeout_o === 1'b1) begin
      if (to_q.size() == 0) check("unexpected_timeout", 32'(timeout_o), 32'd0);
      else begin
        tname = to_q.pop_front();
        check({tname, "_gnt_cleared"}, 32'(gnt_o), 32'd0);
        check({tname, "_host_rst"}, 32'(host_rst), 32'd1);
      end
    end
    gnt_prev = gnt_o;
  end

  initial begin
    int cnt;
    logic [1:0] g_seen;
    rst = 1'b0; req_i = 2'b00;
    r_block_i = 2'b00; r_multi_block_i = 2'b00; r_byte_i = 2'b00;
    w_block_i = 2'b00; w_byte_i = 2'b00;
    block_addr_i = 64'd0; data_in_i = 16'd0;
    host_busy = 1'b1; host_err = 1'b0; host_data_out = 8'd0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_host_rst", 32'(host_rst), 32'd1);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd3);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_strobe", 32'(host_r_block), 32'd0);
    check("rst_addr", host_block_addr, 32'd0);

    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && host_rst === 1'b1; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("init_rst_len", 32'(cnt), 32'(RC));
    check("wait_rdy_busy_view", 32'(busy_o), 32'd3);
    repeat (2) @(negedge clk);
    host_busy = 1'b0;
    @(negedge clk);
    check("idle_busy_view", 32'(busy_o), 32'd3);
    check("idle_gnt", 32'(gnt_o), 32'd0);

    // Tie after reset: requester 0 first, then requester 1
    push_gnt("tie_first", 2'b01);
    req_i = 2'b11;
    wait_gnt(2'b01, "tie_first");
    check("tie_owner_busy", 32'(busy_o), 32'd2);
    push_gnt("tie_second", 2'b10);
    req_i = 2'b10;
    wait_gnt(2'b10, "tie_second");
    check("tie_nonowner_busy0", 32'(busy_o[0]), 32'd1);
    req_i = 2'b00;
    wait_gnt(2'b00, "tie_release");

    // Single owner forwarding
    block_addr_i = {32'hDEAD_BEEF, 32'h0000_0100};
    data_in_i = {8'hC3, 8'h5A};
    push_gnt("single_gnt", 2'b01);
    req_i = 2'b01;
    wait_gnt(2'b01, "single_gnt");
    r_block_i = 2'b01; host_data_out = 8'h77; host_err = 1'b1;
    #1;
    check("single_r_block", 32'(host_r_block), 32'd1);
    check("single_addr", host_block_addr, 32'h100);
    check("single_wdata", 32'(host_data_in), 32'h5A);
    check("single_rdata", 32'(data_out_o), 32'h77);
    check("single_err_view", 32'(err_o), 32'd1);

    // Intruder strobe from requester 1 is dropped
    r_block_i = 2'b00; r_byte_i = 2'b10;
    #1;
    check("intruder_r_byte", 32'(host_r_byte), 32'd0);
    check("intruder_busy1", 32'(busy_o[1]), 32'd1);
    check("intruder_err1", 32'(err_o[1]), 32'd0);
    r_byte_i = 2'b01;
    #1;
    check("owner_r_byte", 32'(host_r_byte), 32'd1);
    r_byte_i = 2'b00; host_err = 1'b0;
    @(negedge clk);

    // Drain: owner releases while host busy, other requester waits
    host_busy = 1'b1;
    @(negedge clk);
    push_gnt("drain_regrant", 2'b10);
    req_i = 2'b10; r_block_i = 2'b01;
    @(negedge clk);
    check("drain_strobe_forced", 32'(host_r_block), 32'd0);
    g_seen = 2'b00;
    repeat (20) begin
      g_seen |= gnt_o;
      @(negedge clk);
    end
    check("drain_hold_gnt", 32'(g_seen), 32'd0);
    host_busy = 1'b0; r_block_i = 2'b00;
    @(negedge clk);
    check("drain_exit_no_gnt", 32'(gnt_o), 32'd0);
    @(negedge clk);
    check("drain_regrant_time", 32'(gnt_o), 32'd2);
    req_i = 2'b00;
    wait_gnt(2'b00, "drain_release");
    @(negedge clk);

    // Timeout: host busy stuck while granted
    push_gnt("to_gnt", 2'b01);
    req_i = 2'b01;
    wait_gnt(2'b01, "to_gnt");
    host_busy = 1'b1;
    to_q.push_back("timeout");
    cnt = 0;
    for (int i = 0; i < 100 && timeout_o !== 1'b1; i++) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_latency", 32'(cnt >= (2**TW - 1) && cnt <= (2**TW + 3)), 32'd1);
    @(negedge clk);
    check("timeout_one_cycle", 32'(timeout_o), 32'd0);
    check("timeout_rst_held", 32'(host_rst), 32'd1);
    req_i = 2'b00; host_busy = 1'b0;
    for (int i = 0; i < 40 && host_rst === 1'b1; i++) @(negedge clk);
    check("recover_rst_low", 32'(host_rst), 32'd0);
    @(negedge clk);
    push_gnt("recover_gnt", 2'b10);
    req_i = 2'b10;
    wait_gnt(2'b10, "recover_gnt");
    req_i = 2'b00;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(gnt_q.size() + to_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
